// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader.
//   - Default UART bit period and the idle line level.
//   - State encodings for the UART receive FSM and the loader FSM.
package loader_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 868;
    localparam logic        UART_IDLE_LVL    = 1'b1;

    // UART receive FSM
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Program loader FSM
    typedef enum logic [2:0] {
        LD_LEN  = 3'd0,
        LD_HI   = 3'd1,
        LD_LO   = 3'd2,
        LD_CHK  = 3'd3,
        LD_DONE = 3'd4
    } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, bit timer and receive FSM.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_i                raw serial line (asynchronous, idles high)
//   byte_valid_o        one-cycle pulse when a byte with a good stop bit arrives
//   byte_data_o[7:0]    received byte, valid with byte_valid_o
//   rx_busy_o           high from start-bit detection until the stop bit is sampled
//   frame_err_pulse_o   one-cycle pulse when the stop bit is sampled low
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       rx_busy_o,
    output logic       frame_err_pulse_o
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] HALF_T = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_T = TMR_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [TMR_W-1:0] tmr_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             valid_q;
    logic             busy_q;
    logic             ferr_q;

    // Synchroniser, edge detect and receive FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            sync1_q <= UART_IDLE_LVL;
            sync2_q <= UART_IDLE_LVL;
            prev_q  <= UART_IDLE_LVL;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    // Only a high-to-low transition starts a frame, so a line
                    // left low after a framing error does not retrigger.
                    if (prev_q && !sync2_q) begin
                        state_q <= RX_START;
                        tmr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RX_START: begin
                    if (tmr_q == HALF_T) begin
                        tmr_q <= '0;
                        if (!sync2_q) begin
                            state_q <= RX_DATA;
                            bit_q   <= '0;
                        end else begin
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                RX_DATA: begin
                    if (tmr_q == FULL_T) begin
                        tmr_q   <= '0;
                        shift_q <= {sync2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                RX_STOP: begin
                    if (tmr_q == FULL_T) begin
                        tmr_q   <= '0;
                        state_q <= RX_IDLE;
                        busy_q  <= 1'b0;
                        if (sync2_q) begin
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_valid_o      = valid_q;
    assign byte_data_o       = shift_q;
    assign rx_busy_o         = busy_q;
    assign frame_err_pulse_o = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// UART program loader: receives a length byte followed by big-endian 16-bit
// words over UART and writes them sequentially into instruction memory.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   uart_rx           serial input (8N1, LSB first, idles high)
//   wr_en             one-cycle instruction-memory write strobe
//   wr_addr, wr_data  write address / data, valid with wr_en
//   load_done         program complete; held until RST
//   rx_busy           a UART byte is being received
//   frame_err         sticky: a stop bit was sampled low
//   chk_err           sticky checksum mismatch (0 when checksum is disabled)
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              uart_rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              load_done,
    output logic              rx_busy,
    output logic              frame_err,
    output logic              chk_err
);

    // One extra bit so a full 2**ADDR_W-word program is representable.
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err_pulse;

    ld_state_t         state_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        hi_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              done_q;
    logic              ferr_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
    logic              chk_err_q;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk               (CLK),
        .rst               (RST),
        .rx_i              (uart_rx),
        .byte_valid_o      (byte_valid),
        .byte_data_o       (byte_data),
        .rx_busy_o         (rx_busy),
        .frame_err_pulse_o (frame_err_pulse)
    );

    // Loader FSM, word counter, write port and sticky flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= LD_LEN;
            len_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= '0;
            chk_err_q <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            if (frame_err_pulse) begin
                ferr_q <= 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            // Checksum covers the length byte and every data byte.
            if (byte_valid && (state_q == LD_LEN || state_q == LD_HI || state_q == LD_LO)) begin
                csum_q <= csum_q ^ byte_data;
            end
`endif
            case (state_q)
                LD_LEN: begin
                    if (byte_valid) begin
                        // A length byte of zero means a full memory image.
                        len_q   <= (byte_data == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(byte_data);
                        state_q <= LD_HI;
                    end
                end
                LD_HI: begin
                    if (byte_valid) begin
                        hi_q    <= byte_data;
                        state_q <= LD_LO;
                    end
                end
                LD_LO: begin
                    if (byte_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q[ADDR_W-1:0];
                        wr_data_q <= DATA_W'({hi_q, byte_data});
                        cnt_q     <= cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_q <= LD_CHK;
`else
                            state_q <= LD_DONE;
`endif
                        end else begin
                            state_q <= LD_HI;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CHK: begin
                    if (byte_valid) begin
                        state_q <= LD_DONE;
                        if (byte_data != csum_q) begin
                            chk_err_q <= 1'b1;
                        end
                    end
                end
`endif
                LD_DONE: begin
                    // Absorbing; load_done lags the final write by one cycle.
`ifdef LOADER_CHECKSUM_EN
                    done_q <= ~chk_err_q;
`else
                    done_q <= 1'b1;
`endif
                end
                default: begin
                    state_q <= LD_LEN;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign load_done = done_q;
    assign frame_err = ferr_q;
`ifdef LOADER_CHECKSUM_EN
    assign chk_err   = chk_err_q;
`else
    assign chk_err   = 1'b0;
`endif

endmodule
